// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size codes and FSM state encoding for the MEM stage
package mem_pkg;

    localparam logic [1:0] BYTE      = 2'b00;
    localparam logic [1:0] HALF_WORD = 2'b01;
    localparam logic [1:0] WORD      = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/xilinx_one_port_ram_async.sv
// rtl/xilinx_one_port_ram_async.sv - single-port RAM, synchronous write, asynchronous read
module xilinx_one_port_ram_async #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            ram[addr] <= din;
        end
    end

    assign dout = ram[addr];

endmodule

// File: rtl/etapa_mem_multiciclo.sv
// rtl/etapa_mem_multiciclo.sv - multicycle MEM stage: one RAM lane per beat, stalls upstream
// until half/word accesses complete, registers the MEM/WB outputs.
module etapa_mem_multiciclo
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int LANE_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [REG_ADDR_WIDTH-1:0] i_write_reg,
    input  logic [DATA_WIDTH-1:0]     i_data_to_write_in_MEM,
    input  logic [DATA_WIDTH-1:0]     i_ALU_result,
    input  logic                      i_WB_write,
    input  logic                      i_WB_mem_to_reg,
    input  logic                      i_MEM_read,
    input  logic                      i_MEM_write,
    input  logic                      i_MEM_unsigned,
    input  logic [1:0]                i_MEM_byte_half_word,
    output logic                      o_stall,
    output logic                      o_WB_write,
    output logic                      o_WB_mem_to_reg,
    output logic [DATA_WIDTH-1:0]     o_ALU_result,
    output logic [DATA_WIDTH-1:0]     o_read_data,
    output logic [REG_ADDR_WIDTH-1:0] o_write_reg,
    output logic                      o_misaligned
);

    localparam int MAX_BEATS = DATA_WIDTH / LANE_WIDTH;
    localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int HALF_W    = DATA_WIDTH / 2;

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic [DATA_WIDTH-1:0]     l_addr;
    logic [DATA_WIDTH-1:0]     l_data;
    logic [1:0]                l_size;
    logic                      l_uns;
    logic                      l_load;
    logic                      l_store;
    logic                      l_wb_write;
    logic                      l_m2r;
    logic [REG_ADDR_WIDTH-1:0] l_wreg;
    logic [DATA_WIDTH-1:0]     acc;

    logic                      busy;
    logic                      mem_op;
    logic [DATA_WIDTH-1:0]     c_addr;
    logic [DATA_WIDTH-1:0]     c_data;
    logic [1:0]                c_size;
    logic                      c_uns;
    logic                      c_load;
    logic                      c_store;
    logic [CNT_W:0]            n_beats;
    logic [CNT_W-1:0]          beat;
    int                        beat_i;
    logic                      last_beat;
    logic                      misaligned;
    logic                      start_multi;
    logic [ADDR_WIDTH-1:0]     ram_addr;
    logic                      ram_we;
    logic [LANE_WIDTH-1:0]     ram_din;
    logic [LANE_WIDTH-1:0]     ram_dout;
    logic [DATA_WIDTH-1:0]     assembled;
    logic [DATA_WIDTH-1:0]     load_ext;
    logic [DATA_WIDTH-1:0]     rd_final;

    function automatic logic [CNT_W:0] beats_of(input logic [1:0] sz);
        case (sz)
            BYTE:      beats_of = (CNT_W+1)'(1);
            HALF_WORD: beats_of = (CNT_W+1)'(MAX_BEATS / 2);
            default:   beats_of = (CNT_W+1)'(MAX_BEATS);
        endcase
    endfunction

    // In BUSY every beat works from the latched instruction; live inputs are frozen upstream.
    assign busy    = (state == BUSY);
    assign mem_op  = i_MEM_read | i_MEM_write;
    assign c_addr  = busy ? l_addr  : i_ALU_result;
    assign c_data  = busy ? l_data  : i_data_to_write_in_MEM;
    assign c_size  = busy ? l_size  : i_MEM_byte_half_word;
    assign c_uns   = busy ? l_uns   : i_MEM_unsigned;
    assign c_store = busy ? l_store : i_MEM_write;
    assign c_load  = busy ? l_load  : (i_MEM_read & ~i_MEM_write);
    assign n_beats = beats_of(c_size);
    assign beat    = busy ? cnt : '0;
    assign beat_i  = int'(beat);
    assign last_beat = ({1'b0, beat} == (n_beats - (CNT_W+1)'(1)));

    always_comb begin
        misaligned = 1'b0;
        if (!busy && mem_op) begin
            case (i_MEM_byte_half_word)
                BYTE:      misaligned = 1'b0;
                HALF_WORD: misaligned = i_ALU_result[0];
                default:   misaligned = (i_ALU_result[1:0] != 2'b00);
            endcase
        end
    end

    assign start_multi = !busy && mem_op && !misaligned && (n_beats > (CNT_W+1)'(1));
    assign o_stall     = i_reset_n && (start_multi || (busy && !last_beat));

    assign ram_addr = c_addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(beat);
    assign ram_we   = i_reset_n && c_store && !misaligned;
    assign ram_din  = c_data[beat_i*LANE_WIDTH +: LANE_WIDTH];

    xilinx_one_port_ram_async #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (LANE_WIDTH)
    ) u_ram (
        .clk  (i_clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    // Lanes below the current beat come from acc; lanes above it are don't-care for the size.
    always_comb begin
        assembled = acc;
        assembled[beat_i*LANE_WIDTH +: LANE_WIDTH] = ram_dout;
    end

    always_comb begin
        case (c_size)
            BYTE: load_ext = c_uns
                ? {{(DATA_WIDTH-LANE_WIDTH){1'b0}}, assembled[LANE_WIDTH-1:0]}
                : {{(DATA_WIDTH-LANE_WIDTH){assembled[LANE_WIDTH-1]}}, assembled[LANE_WIDTH-1:0]};
            HALF_WORD: load_ext = c_uns
                ? {{(DATA_WIDTH-HALF_W){1'b0}}, assembled[HALF_W-1:0]}
                : {{(DATA_WIDTH-HALF_W){assembled[HALF_W-1]}}, assembled[HALF_W-1:0]};
            default: load_ext = assembled;
        endcase
    end

    assign rd_final = c_load ? load_ext : '0;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            o_WB_write      <= 1'b0;
            o_WB_mem_to_reg <= 1'b0;
            o_ALU_result    <= '0;
            o_read_data     <= '0;
            o_write_reg     <= '0;
            o_misaligned    <= 1'b0;
        end else begin
            o_misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (misaligned) begin
                        o_misaligned    <= 1'b1;
                        o_WB_write      <= 1'b0;
                        o_WB_mem_to_reg <= 1'b0;
                        o_ALU_result    <= i_ALU_result;
                        o_read_data     <= '0;
                        o_write_reg     <= i_write_reg;
                    end else if (start_multi) begin
                        l_addr     <= i_ALU_result;
                        l_data     <= i_data_to_write_in_MEM;
                        l_size     <= i_MEM_byte_half_word;
                        l_uns      <= i_MEM_unsigned;
                        l_load     <= i_MEM_read & ~i_MEM_write;
                        l_store    <= i_MEM_write;
                        l_wb_write <= i_WB_write;
                        l_m2r      <= i_WB_mem_to_reg;
                        l_wreg     <= i_write_reg;
                        acc[LANE_WIDTH-1:0] <= ram_dout;
                        o_WB_write      <= 1'b0;
                        o_WB_mem_to_reg <= 1'b0;
                        o_ALU_result    <= '0;
                        o_read_data     <= '0;
                        o_write_reg     <= '0;
                        cnt   <= CNT_W'(1);
                        state <= BUSY;
                    end else begin
                        o_WB_write      <= i_WB_write;
                        o_WB_mem_to_reg <= i_WB_mem_to_reg;
                        o_ALU_result    <= i_ALU_result;
                        o_read_data     <= rd_final;
                        o_write_reg     <= i_write_reg;
                    end
                end
                BUSY: begin
                    if (!last_beat) begin
                        acc[beat_i*LANE_WIDTH +: LANE_WIDTH] <= ram_dout;
                        o_WB_write      <= 1'b0;
                        o_WB_mem_to_reg <= 1'b0;
                        o_ALU_result    <= '0;
                        o_read_data     <= '0;
                        o_write_reg     <= '0;
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        o_WB_write      <= l_wb_write;
                        o_WB_mem_to_reg <= l_m2r;
                        o_ALU_result    <= l_addr;
                        o_read_data     <= rd_final;
                        o_write_reg     <= l_wreg;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_etapa_mem_multiciclo.sv
// tb/tb_etapa_mem_multiciclo.sv - directed vector bench for the multicycle MEM stage
module tb_etapa_mem_multiciclo;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [4:0]  i_write_reg;
    logic [31:0] i_data_to_write_in_MEM;
    logic [31:0] i_ALU_result;
    logic        i_WB_write;
    logic        i_WB_mem_to_reg;
    logic        i_MEM_read;
    logic        i_MEM_write;
    logic        i_MEM_unsigned;
    logic [1:0]  i_MEM_byte_half_word;
    logic        o_stall;
    logic        o_WB_write;
    logic        o_WB_mem_to_reg;
    logic [31:0] o_ALU_result;
    logic [31:0] o_read_data;
    logic [4:0]  o_write_reg;
    logic        o_misaligned;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        uns;
        logic [1:0]  sz;
        logic [31:0] alu;
        logic [31:0] data;
        logic [4:0]  wreg;
        logic        wbw;
        logic        m2r;
        int          stalls;
        logic [31:0] e_rdata;
        logic [31:0] e_alu;
        logic [4:0]  e_wreg;
        logic        e_wbw;
        logic        e_mis;
    } vec_t;

    vec_t vq[$];
    vec_t post[$];

    etapa_mem_multiciclo dut (
        .i_clk                  (i_clk),
        .i_reset_n              (i_reset_n),
        .i_write_reg            (i_write_reg),
        .i_data_to_write_in_MEM (i_data_to_write_in_MEM),
        .i_ALU_result           (i_ALU_result),
        .i_WB_write             (i_WB_write),
        .i_WB_mem_to_reg        (i_WB_mem_to_reg),
        .i_MEM_read             (i_MEM_read),
        .i_MEM_write            (i_MEM_write),
        .i_MEM_unsigned         (i_MEM_unsigned),
        .i_MEM_byte_half_word   (i_MEM_byte_half_word),
        .o_stall                (o_stall),
        .o_WB_write             (o_WB_write),
        .o_WB_mem_to_reg        (o_WB_mem_to_reg),
        .o_ALU_result           (o_ALU_result),
        .o_read_data            (o_read_data),
        .o_write_reg            (o_write_reg),
        .o_misaligned           (o_misaligned)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t ld(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                                input logic [31:0] exp, input int st);
        ld = '{1'b1, 1'b0, uns, sz, a, 32'h0, 5'd5, 1'b1, 1'b1,
               st, exp, a, 5'd5, 1'b1, 1'b0};
    endfunction

    function automatic vec_t sto(input logic [1:0] sz, input logic [31:0] a,
                                 input logic [31:0] d, input int st);
        sto = '{1'b0, 1'b1, 1'b0, sz, a, d, 5'd0, 1'b0, 1'b0,
                st, 32'h0, a, 5'd0, 1'b0, 1'b0};
    endfunction

    task automatic drive(input vec_t v);
        i_MEM_read             = v.rd;
        i_MEM_write            = v.wr;
        i_MEM_unsigned         = v.uns;
        i_MEM_byte_half_word   = v.sz;
        i_ALU_result           = v.alu;
        i_data_to_write_in_MEM = v.data;
        i_write_reg            = v.wreg;
        i_WB_write             = v.wbw;
        i_WB_mem_to_reg        = v.m2r;
    endtask

    // Inputs are held while o_stall is high, as a frozen upstream stage would do.
    task automatic run_vec(input vec_t v, input string tag);
        int stalls;
        drive(v);
        #1;
        stalls = 0;
        while (o_stall && stalls < 8) begin
            @(posedge i_clk);
            #1;
            stalls++;
            chk({tag, "_bubble"},
                {31'h0, o_WB_write | o_WB_mem_to_reg | (|o_write_reg) | (|o_read_data) | (|o_ALU_result)},
                32'h0);
        end
        chk({tag, "_stalls"}, stalls, v.stalls);
        @(posedge i_clk);
        #1;
        chk({tag, "_rdata"}, o_read_data, v.e_rdata);
        chk({tag, "_alu"},   o_ALU_result, v.e_alu);
        chk({tag, "_wreg"},  {27'h0, o_write_reg}, {27'h0, v.e_wreg});
        chk({tag, "_wbw"},   {31'h0, o_WB_write}, {31'h0, v.e_wbw});
        chk({tag, "_mis"},   {31'h0, o_misaligned}, {31'h0, v.e_mis});
    endtask

    initial begin
        vq.push_back(sto(2'b11, 32'h010, 32'hDEADBEEF, 3));
        vq.push_back(ld (2'b11, 1'b0, 32'h010, 32'hDEADBEEF, 3));
        vq.push_back(ld (2'b00, 1'b0, 32'h010, 32'hFFFFFFEF, 0));
        vq.push_back(ld (2'b00, 1'b1, 32'h013, 32'h000000DE, 0));
        vq.push_back(ld (2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 3));
        vq.push_back(ld (2'b01, 1'b0, 32'h012, 32'hFFFFDEAD, 1));
        vq.push_back(ld (2'b01, 1'b1, 32'h012, 32'h0000DEAD, 1));
        vq.push_back(sto(2'b11, 32'h020, 32'h00000000, 3));
        vq.push_back(sto(2'b01, 32'h020, 32'h00008001, 1));
        vq.push_back(ld (2'b01, 1'b0, 32'h020, 32'hFFFF8001, 1));
        vq.push_back(ld (2'b01, 1'b1, 32'h020, 32'h00008001, 1));
        vq.push_back(ld (2'b00, 1'b1, 32'h022, 32'h00000000, 0));
        // misaligned word load, then a misaligned word store that must not touch RAM
        vq.push_back('{1'b1, 1'b0, 1'b0, 2'b11, 32'h022, 32'h0, 5'd5, 1'b1, 1'b1,
                       0, 32'h0, 32'h022, 5'd5, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b1, 1'b0, 2'b11, 32'h021, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0,
                       0, 32'h0, 32'h021, 5'd0, 1'b0, 1'b1});
        vq.push_back(ld (2'b11, 1'b0, 32'h020, 32'h00008001, 3));
        vq.push_back('{1'b1, 1'b0, 1'b0, 2'b01, 32'h061, 32'h0, 5'd5, 1'b1, 1'b1,
                       0, 32'h0, 32'h061, 5'd5, 1'b0, 1'b1});
        vq.push_back(sto(2'b11, 32'h1030, 32'h11223344, 3));
        vq.push_back(ld (2'b11, 1'b0, 32'h030, 32'h11223344, 3));
        // R-type passthrough
        vq.push_back('{1'b0, 1'b0, 1'b0, 2'b00, 32'h7, 32'h0, 5'd9, 1'b1, 1'b0,
                       0, 32'h0, 32'h7, 5'd9, 1'b1, 1'b0});
        // read and write together behave as a byte store with zero read data
        vq.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 32'h050, 32'h000000A5, 5'd3, 1'b0, 1'b0,
                       0, 32'h0, 32'h050, 5'd3, 1'b0, 1'b0});
        vq.push_back(ld (2'b00, 1'b1, 32'h050, 32'h000000A5, 0));
        vq.push_back(ld (2'b00, 1'b0, 32'h050, 32'hFFFFFFA5, 0));
        vq.push_back(sto(2'b11, 32'h040, 32'h00000000, 3));

        post.push_back(ld(2'b00, 1'b1, 32'h040, 32'h000000DD, 0));
        post.push_back(ld(2'b00, 1'b1, 32'h041, 32'h000000CC, 0));
        post.push_back(ld(2'b00, 1'b1, 32'h042, 32'h00000000, 0));
        post.push_back(ld(2'b00, 1'b1, 32'h043, 32'h00000000, 0));

        i_reset_n = 1'b0;
        drive(sto(2'b11, 32'h000, 32'h12345678, 0));
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_stall", {31'h0, o_stall}, 32'h0);
        chk("rst_outs",
            {31'h0, o_WB_write | o_WB_mem_to_reg | o_misaligned | (|o_write_reg) | (|o_read_data) | (|o_ALU_result)},
            32'h0);
        drive(ld(2'b00, 1'b0, 32'h0, 32'h0, 0));
        i_MEM_read = 1'b0;
        i_reset_n  = 1'b1;
        @(posedge i_clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            run_vec(vq[i], $sformatf("v%0d", i));
        end

        // store aborted by reset after beat 1
        drive(sto(2'b11, 32'h040, 32'hAABBCCDD, 3));
        #1;
        chk("abort_stall0", {31'h0, o_stall}, 32'h1);
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b0;
        #1;
        chk("abort_stall_rst", {31'h0, o_stall}, 32'h0);
        @(posedge i_clk);
        #1;
        chk("abort_stall_after", {31'h0, o_stall}, 32'h0);
        chk("abort_outs",
            {31'h0, o_WB_write | o_WB_mem_to_reg | o_misaligned | (|o_write_reg) | (|o_read_data) | (|o_ALU_result)},
            32'h0);
        drive(ld(2'b00, 1'b0, 32'h0, 32'h0, 0));
        i_MEM_read = 1'b0;
        i_reset_n  = 1'b1;
        for (int i = 0; i < post.size(); i++) begin
            run_vec(post[i], $sformatf("post%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/etapa_mem_multiciclo.md
ETAPA_MEM_MULTICICLO -- requirements
Module: etapa_mem_multiciclo

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, datapath width; ADDR_WIDTH, 12, byte-address bits of data RAM; LANE_WIDTH, 8, RAM port width; REG_ADDR_WIDTH, 5, register-index width.
REQ-002 Ports SHALL be (clock and reset first):
 i_clk  in  1  single clock, all state on rising edge;
 i_reset_n  in  1  synchronous, active-low reset;
 i_write_reg  in  REG_ADDR_WIDTH  WB destination register;
 i_data_to_write_in_MEM  in  DATA_WIDTH  store data;
 i_ALU_result  in  DATA_WIDTH  effective address / ALU result;
 i_WB_write, i_WB_mem_to_reg  in  1  WB control, passed through;
 i_MEM_read, i_MEM_write, i_MEM_unsigned  in  1  load, store, zero-extend;
 i_MEM_byte_half_word  in  2  00 byte, 01 half, 11 word, 10 treated as word;
 o_stall  out  1  combinational, freeze upstream stages;
 o_WB_write, o_WB_mem_to_reg  out  1  registered WB control;
 o_ALU_result, o_read_data  out  DATA_WIDTH  registered;
 o_write_reg  out  REG_ADDR_WIDTH  registered;
 o_misaligned  out  1  registered one-cycle alignment-fault pulse.
REQ-003 Reset SHALL be synchronous and active-low on i_reset_n; the single clock SHALL be i_clk.

Function
REQ-004 Data RAM SHALL be 2**ADDR_WIDTH lanes of LANE_WIDTH, async read, sync write, address = i_ALU_result[ADDR_WIDTH-1:0] (upper bits ignored, aliasing).
REQ-005 Beat count N SHALL be 1 for byte, DATA_WIDTH/(2*LANE_WIDTH) for half, DATA_WIDTH/LANE_WIDTH for word; lane k SHALL occupy bits [k*LANE_WIDTH +: LANE_WIDTH] at base+k (little-endian).
REQ-006 FSM SHALL have states IDLE and BUSY plus beat counter (0..N-1).
REQ-007 IDLE, no memory op or N=1: one-cycle latency, o_stall=0, all outputs registered from current inputs.
REQ-008 IDLE, aligned access with N>1: latch address, store data, size, unsigned, control, write_reg; perform beat 0 this cycle; o_stall=1; go BUSY, counter=1.
REQ-009 BUSY: perform beat at counter using latched values, ignore live inputs; o_stall=1 while counter<N-1; at counter=N-1 o_stall=0, outputs load final result, return IDLE, counter=0.
REQ-010 Every cycle with o_stall=1 SHALL register a bubble: o_WB_write=0, o_WB_mem_to_reg=0, o_write_reg=0, o_read_data=0, o_ALU_result=0.
REQ-011 Load result SHALL be assembled lanes, zero-extended if unsigned else sign-extended from top loaded bit; word ignores unsigned.
REQ-012 Store SHALL write lane k of store data at base+k during beat k only; byte store writes lane 0 once.
REQ-013 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no RAM write, no stall, o_misaligned=1 for one cycle, o_WB_write=0, o_ALU_result=address.
REQ-014 i_MEM_read and i_MEM_write both high SHALL be treated as store; o_read_data=0.
REQ-015 o_read_data SHALL be 0 for non-load instructions.

Reset
REQ-016 i_reset_n=0 at any edge SHALL force IDLE, counter=0, all registered outputs 0; o_stall SHALL be 0 while i_reset_n=0.
REQ-017 Reset mid-access SHALL abort; lanes already written remain, remaining lanes unwritten; RAM contents never reset.

Structure
REQ-018 Size codes (BYTE, HALF_WORD, WORD) and FSM state encodings SHALL live in shared package mem_pkg.
REQ-019 RAM SHALL be instance of existing xilinx_one_port_ram_async (ADDR_WIDTH, DATA_WIDTH=LANE_WIDTH); no other sub-module.

Verification
REQ-020 sw 0xDEADBEEF @0x010 -> o_stall high 3 cycles, bubbles; lw @0x010 -> 0xDEADBEEF on 4th edge; lb @0x010 -> 0xFFFFFFEF; lbu @0x013 -> 0x000000DE, no stall.
REQ-021 sh 0x00008001 @0x020 -> 1 stall cycle; lh -> 0xFFFF8001; lhu -> 0x00008001; byte @0x022 unchanged.
REQ-022 lw @0x022 -> o_misaligned=1 one cycle, o_WB_write=0, no stall, RAM unchanged.
REQ-023 sw 0x11223344 @0x1030 -> lw @0x030 returns 0x11223344 (aliasing).
REQ-024 sw 0xAABBCCDD @0x040 (prior 0), i_reset_n low after beat 1 -> outputs 0, o_stall 0; bytes 0x040=0xDD, 0x041=0xCC, 0x042/0x043=0x00.
REQ-025 R-type (read=write=0) ALU 0x00000007, reg 9, WB_write 1 -> next edge o_ALU_result=7, o_write_reg=9, o_WB_write=1, o_stall never high.
